imm_stage: RTL and testbench

Decode-stage immediate sequencer for the MIPS pipeline. It takes the fetched instruction, picks the extension mode (sign, zero, upper or branch-shift), and drives the shared immediate extender (`ext`). It then registers the extended immediate, together with the instruction and its class, into the ID/EX boundary. It honours pipeline stall and flush, so the extender result always stays aligned with the instruction that produced it.

---
 rtl/imm_stage.sv | 144 ++++++++++++++
 tb/tb_imm_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/imm_stage.sv
// rtl/imm_stage.sv - Decode-stage immediate sequencer driving the shared extender; optional IMM_ILLEGAL_EN adds the Illegal output
module imm_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] InstrIn,
    input  logic        ValidIn,
    input  logic        Stall,
    input  logic        Flush,
    output logic [15:0] ExtIn,
    output logic [1:0]  ExtOp,
    input  logic [31:0] ExtOut,
    output logic [31:0] ImmOut,
    output logic [31:0] InstrOut,
    output logic        ValidOut,
`ifdef IMM_ILLEGAL_EN
    output logic        Illegal,
`endif
    output logic        ImmUsed
);

    typedef enum logic {
        EMPTY  = 1'b0,
        LOADED = 1'b1
    } state_e;

    localparam logic [1:0] EXT_SIGN  = 2'b00;
    localparam logic [1:0] EXT_ZERO  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;
    localparam logic [1:0] EXT_BRANCH = 2'b11;

    state_e      state_q, state_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] instr_q, instr_d;
    logic        used_q, used_d;
    logic [5:0]  opcode;
    logic [1:0]  ext_op;
    logic        is_imm;
`ifdef IMM_ILLEGAL_EN
    logic        is_illegal;
    logic        illegal_q, illegal_d;
`endif

    assign opcode = InstrIn[31:26];
    assign ExtIn  = InstrIn[15:0];
    assign ExtOp  = ext_op;

    // Opcode decode: extender mode, whether an immediate is consumed, and illegal detection
    always_comb begin
        ext_op = EXT_SIGN;
        is_imm = 1'b0;
`ifdef IMM_ILLEGAL_EN
        is_illegal = 1'b0;
`endif
        case (opcode)
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
            6'h28, 6'h29, 6'h2B: begin
                ext_op = EXT_SIGN;
                is_imm = 1'b1;
            end
            6'h0C, 6'h0D, 6'h0E: begin
                ext_op = EXT_ZERO;
                is_imm = 1'b1;
            end
            6'h0F: begin
                ext_op = EXT_UPPER;
                is_imm = 1'b1;
            end
            6'h01, 6'h04, 6'h05, 6'h06, 6'h07: begin
                ext_op = EXT_BRANCH;
                is_imm = 1'b1;
            end
            6'h00, 6'h02, 6'h03: begin
                ext_op = EXT_SIGN;
                is_imm = 1'b0;
            end
            default: begin
                ext_op = EXT_SIGN;
                is_imm = 1'b0;
`ifdef IMM_ILLEGAL_EN
                is_illegal = 1'b1;
`endif
            end
        endcase
    end

    // Next-state: flush beats stall; an invalid input loads a bubble just like a flush
    always_comb begin
        state_d = state_q;
        imm_d   = imm_q;
        instr_d = instr_q;
        used_d  = used_q;
`ifdef IMM_ILLEGAL_EN
        illegal_d = illegal_q;
`endif
        if (Flush || (!Stall && !ValidIn)) begin
            state_d = EMPTY;
            imm_d   = 32'h0;
            instr_d = 32'h0;
            used_d  = 1'b0;
`ifdef IMM_ILLEGAL_EN
            illegal_d = 1'b0;
`endif
        end else if (!Stall) begin
            state_d = LOADED;
            imm_d   = is_imm ? ExtOut : 32'h0;
            instr_d = InstrIn;
            used_d  = is_imm;
`ifdef IMM_ILLEGAL_EN
            illegal_d = is_illegal;
`endif
        end
    end

    // ID/EX boundary registers; reset clears them without waiting for a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            imm_q   <= 32'h0;
            instr_q <= 32'h0;
            used_q  <= 1'b0;
`ifdef IMM_ILLEGAL_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            imm_q   <= imm_d;
            instr_q <= instr_d;
            used_q  <= used_d;
`ifdef IMM_ILLEGAL_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    assign ValidOut = (state_q == LOADED);
    assign ImmOut   = imm_q;
    assign InstrOut = instr_q;
    assign ImmUsed  = used_q;
`ifdef IMM_ILLEGAL_EN
    assign Illegal  = illegal_q;
`endif

endmodule

// File: tb/tb_imm_stage.sv
// tb/tb_imm_stage.sv - Directed self-checking bench for imm_stage
`timescale 1ns/1ps
module tb_imm_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] InstrIn;
    logic        ValidIn;
    logic        Stall;
    logic        Flush;
    logic [15:0] ExtIn;
    logic [1:0]  ExtOp;
    logic [31:0] ExtOut;
    logic [31:0] ImmOut;
    logic [31:0] InstrOut;
    logic        ValidOut;
    logic        ImmUsed;
`ifdef IMM_ILLEGAL_EN
    logic        Illegal;
`endif

    int checks = 0;
    int errors = 0;

    imm_stage dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .InstrIn  (InstrIn),
        .ValidIn  (ValidIn),
        .Stall    (Stall),
        .Flush    (Flush),
        .ExtIn    (ExtIn),
        .ExtOp    (ExtOp),
        .ExtOut   (ExtOut),
        .ImmOut   (ImmOut),
        .InstrOut (InstrOut),
        .ValidOut (ValidOut),
`ifdef IMM_ILLEGAL_EN
        .Illegal  (Illegal),
`endif
        .ImmUsed  (ImmUsed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the shared extender the block drives
    always_comb begin
        case (ExtOp)
            2'b00:   ExtOut = {{16{ExtIn[15]}}, ExtIn};
            2'b01:   ExtOut = {16'h0, ExtIn};
            2'b10:   ExtOut = {ExtIn, 16'h0};
            default: ExtOut = {{14{ExtIn[15]}}, ExtIn, 2'b00};
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic v, input logic st, input logic fl);
        InstrIn = instr;
        ValidIn = v;
        Stall   = st;
        Flush   = fl;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (ImmOut !== 32'h0) begin errors++; $display("FAIL reset_imm got %h exp %h", ImmOut, 32'h0); end
        checks++; if (InstrOut !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp %h", InstrOut, 32'h0); end
        checks++; if (ValidOut !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ValidOut); end
        checks++; if (ImmUsed !== 1'b0) begin errors++; $display("FAIL reset_used got %b exp 0", ImmUsed); end
        #11 rst_n = 1'b1;
        step();
    endtask

    task automatic test_sign();
        drive(32'h2008FFFC, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (ExtOp !== 2'b00) begin errors++; $display("FAIL sign_extop got %b exp 00", ExtOp); end
        checks++; if (ExtIn !== 16'hFFFC) begin errors++; $display("FAIL sign_extin got %h exp fffc", ExtIn); end
        step();
        checks++; if (ImmOut !== 32'hFFFFFFFC) begin errors++; $display("FAIL sign_imm got %h exp fffffffc", ImmOut); end
        checks++; if (ImmUsed !== 1'b1) begin errors++; $display("FAIL sign_used got %b exp 1", ImmUsed); end
        checks++; if (ValidOut !== 1'b1) begin errors++; $display("FAIL sign_valid got %b exp 1", ValidOut); end
        checks++; if (InstrOut !== 32'h2008FFFC) begin errors++; $display("FAIL sign_instr got %h exp 2008fffc", InstrOut); end
    endtask

    task automatic test_back_to_back();
        drive(32'h34088000, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (ExtOp !== 2'b01) begin errors++; $display("FAIL ori_extop got %b exp 01", ExtOp); end
        step();
        checks++; if (ImmOut !== 32'h00008000) begin errors++; $display("FAIL ori_imm got %h exp 00008000", ImmOut); end
        drive(32'h3C081234, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (ExtOp !== 2'b10) begin errors++; $display("FAIL lui_extop got %b exp 10", ExtOp); end
        step();
        checks++; if (ImmOut !== 32'h12340000) begin errors++; $display("FAIL lui_imm got %h exp 12340000", ImmOut); end
        checks++; if (ValidOut !== 1'b1) begin errors++; $display("FAIL lui_valid got %b exp 1", ValidOut); end
        checks++; if (InstrOut !== 32'h3C081234) begin errors++; $display("FAIL lui_instr got %h exp 3c081234", InstrOut); end
    endtask

    task automatic test_branch();
        drive(32'h1109FFFF, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (ExtOp !== 2'b11) begin errors++; $display("FAIL beq_extop got %b exp 11", ExtOp); end
        step();
        checks++; if (ImmOut !== 32'hFFFFFFFC) begin errors++; $display("FAIL beq_imm got %h exp fffffffc", ImmOut); end
        checks++; if (ImmUsed !== 1'b1) begin errors++; $display("FAIL beq_used got %b exp 1", ImmUsed); end
        drive(32'h01095020, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (ImmOut !== 32'h0) begin errors++; $display("FAIL rtype_imm got %h exp 0", ImmOut); end
        checks++; if (ImmUsed !== 1'b0) begin errors++; $display("FAIL rtype_used got %b exp 0", ImmUsed); end
        checks++; if (ValidOut !== 1'b1) begin errors++; $display("FAIL rtype_valid got %b exp 1", ValidOut); end
    endtask

    task automatic test_stall_flush();
        logic [31:0] stall_instr [3];
        stall_instr[0] = 32'h3C08FFFF;
        stall_instr[1] = 32'h1109FFFF;
        stall_instr[2] = 32'h34080001;
        drive(32'h20080005, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (ImmOut !== 32'h5) begin errors++; $display("FAIL addi5_imm got %h exp 5", ImmOut); end
        for (int i = 0; i < 3; i++) begin
            drive(stall_instr[i], 1'b1, 1'b1, 1'b0);
            step();
            checks++; if (ImmOut !== 32'h5) begin errors++; $display("FAIL stall_imm[%0d] got %h exp 5", i, ImmOut); end
            checks++; if (InstrOut !== 32'h20080005) begin errors++; $display("FAIL stall_instr[%0d] got %h exp 20080005", i, InstrOut); end
        end
        drive(32'h34080001, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (ImmOut !== 32'h1) begin errors++; $display("FAIL stall_release_imm got %h exp 1", ImmOut); end
        drive(32'h3C08FFFF, 1'b1, 1'b1, 1'b1);
        step();
        checks++; if (ValidOut !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", ValidOut); end
        checks++; if (ImmOut !== 32'h0) begin errors++; $display("FAIL flush_imm got %h exp 0", ImmOut); end
        checks++; if (InstrOut !== 32'h0) begin errors++; $display("FAIL flush_instr got %h exp 0", InstrOut); end
        drive(32'h2008FFFC, 1'b1, 1'b0, 1'b0);
        step();
        drive(32'h2008FFFC, 1'b0, 1'b0, 1'b0);
        step();
        checks++; if (ValidOut !== 1'b0) begin errors++; $display("FAIL bubble_valid got %b exp 0", ValidOut); end
        checks++; if (ImmOut !== 32'h0) begin errors++; $display("FAIL bubble_imm got %h exp 0", ImmOut); end
        checks++; if (ImmUsed !== 1'b0) begin errors++; $display("FAIL bubble_used got %b exp 0", ImmUsed); end
    endtask

    task automatic test_reset_mid();
        drive(32'h20080005, 1'b1, 1'b0, 1'b0);
        step();
        drive(32'h20080007, 1'b1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ValidOut !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", ValidOut); end
        checks++; if (ImmOut !== 32'h0) begin errors++; $display("FAIL midrst_imm got %h exp 0", ImmOut); end
        checks++; if (InstrOut !== 32'h0) begin errors++; $display("FAIL midrst_instr got %h exp 0", InstrOut); end
        checks++; if (ImmUsed !== 1'b0) begin errors++; $display("FAIL midrst_used got %b exp 0", ImmUsed); end
        #3 rst_n = 1'b1;
        drive(32'h8C080010, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (ImmOut !== 32'h10) begin errors++; $display("FAIL lw_imm got %h exp 10", ImmOut); end
        checks++; if (ValidOut !== 1'b1) begin errors++; $display("FAIL lw_valid got %b exp 1", ValidOut); end
    endtask

    task automatic test_illegal();
        drive(32'hFC001234, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (ImmOut !== 32'h0) begin errors++; $display("FAIL illegal_imm got %h exp 0", ImmOut); end
        checks++; if (ValidOut !== 1'b1) begin errors++; $display("FAIL illegal_valid got %b exp 1", ValidOut); end
        checks++; if (ImmUsed !== 1'b0) begin errors++; $display("FAIL illegal_used got %b exp 0", ImmUsed); end
`ifdef IMM_ILLEGAL_EN
        checks++; if (Illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag got %b exp 1", Illegal); end
        drive(32'h20080005, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (Illegal !== 1'b0) begin errors++; $display("FAIL legal_flag got %b exp 0", Illegal); end
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_sign();
        test_back_to_back();
        test_branch();
        test_stall_flush();
        test_reset_mid();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
